// File: rtl/vec_load_if.sv
// LDV issue operands, data-memory read port and assembled vector for vec_load_unit.
// slave is the load unit side; master is the requester/memory side.
interface vec_load_if #(
   parameter int unsigned LANES = 4
);
   logic                  start;
   logic [31:0]           i_in;
   logic [31:0]           j_in;
   logic [31:0]           n_in;
   logic                  mem_rd_en;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_rdata;
   logic                  mem_rvalid;
   logic [32*LANES-1:0]   vec_out;
   logic                  vec_valid;
   logic                  busy;

   modport master (
      output start, i_in, j_in, n_in, mem_rdata, mem_rvalid,
      input  mem_rd_en, mem_addr, vec_out, vec_valid, busy
   );

   modport slave (
      input  start, i_in, j_in, n_in, mem_rdata, mem_rvalid,
      output mem_rd_en, mem_addr, vec_out, vec_valid, busy
   );
endinterface

// File: rtl/vec_load_unit.sv
// Vector load unit: fetches LANES consecutive words of matrix row i starting at column j,
// wrapping within the row, one outstanding read at a time.
module vec_load_unit #(
   parameter int unsigned LANES     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input logic       clk,
   input logic       rst,
   vec_load_if.slave bus
);
   localparam int unsigned   KW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [KW-1:0] LAST = KW'(LANES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [31:0]   i_q;
   logic [31:0]   j_q;
   logic [31:0]   n_q;

   // Column wraps back into the same row; address arithmetic is modulo 2^32.
   function automatic logic [31:0] lane_addr(input logic [31:0] i, input logic [31:0] j,
                                             input logic [31:0] n, input logic [KW-1:0] lane);
      logic [31:0] col;
      col = j + 32'(lane);
      if (col > n)
         col = col - (n + 32'd1);
      return BASE_ADDR + ((i * (n + 32'd1) + col) << 2);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         k             <= '0;
         i_q           <= '0;
         j_q           <= '0;
         n_q           <= '0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_addr  <= '0;
         bus.vec_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.vec_out   <= '0;
      end else begin
         bus.mem_rd_en <= 1'b0;
         bus.vec_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  i_q           <= bus.i_in;
                  j_q           <= bus.j_in;
                  n_q           <= bus.n_in;
                  k             <= '0;
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= lane_addr(bus.i_in, bus.j_in, bus.n_in, '0);
                  bus.busy      <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (bus.mem_rvalid) begin
                  bus.vec_out[32*32'(k) +: 32] <= bus.mem_rdata;
                  if (k == LAST) begin
                     bus.vec_valid <= 1'b1;
                     state         <= DONE;
                  end else begin
                     // Next request leaves together with entry to ISSUE so mem_rd_en stays registered.
                     k             <= k + KW'(1);
                     bus.mem_rd_en <= 1'b1;
                     bus.mem_addr  <= lane_addr(i_q, j_q, n_q, k + KW'(1));
                     state         <= ISSUE;
                  end
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vec_load_unit.sv
// Directed bench for vec_load_unit: per-cycle comparison against a transaction-level model,
// plus literal address/data/latency expectations for each scenario.
module tb_vec_load_unit;
   localparam int L = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vec_load_if #(.LANES(L)) bus ();
   vec_load_if #(.LANES(L)) bus1 ();

   vec_load_unit #(.LANES(L), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   vec_load_unit #(.LANES(L), .BASE_ADDR(32'hFFFF_FFF0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   int checks = 0;
   int errors = 0;

   // transaction-level model of dut
   bit             m_busy, m_issue, m_wait, m_vv;
   int             m_lane, m_cyc, last_lat, vv_cnt, rd_cnt;
   logic [32*L-1:0] m_vec;
   logic [31:0]    exp_addr [L];
   logic [31:0]    addr_q [$];

   // memory responders
   int          lat = 1;
   bit          pend, nxt_rv, nxt1;
   int          cnt;
   logic [31:0] paddr, nxt_data, nxt1_data;
   logic [31:0] addr1_q [$];
   int          vv1_cnt;

   task automatic chk(input string nm, input logic [32*L-1:0] act, input logic [32*L-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [31:0] i,
                                              input logic [31:0] j, input logic [31:0] n, input int k);
      logic [63:0] col, w, a;
      col = 64'(j) + 64'(k);
      if (col > 64'(n)) col = col - (64'(n) + 64'd1);
      w = (64'(i) * (64'(n) + 64'd1) + col) % 64'h1_0000_0000;
      a = (64'(base) + 64'd4 * w) % 64'h1_0000_0000;
      return a[31:0];
   endfunction

   // Predict the effect of the upcoming clock edge from the inputs held this cycle.
   task automatic model_step();
      bit ni, nv;
      ni = 1'b0;
      nv = 1'b0;
      if (rst) begin
         m_busy = 0; m_wait = 0; m_lane = 0; m_vec = '0;
      end else if (m_vv) begin
         m_busy = 0;
      end else if (!m_busy && bus.start) begin
         m_busy = 1; m_lane = 0; m_cyc = 0; ni = 1;
         for (int k = 0; k < L; k++)
            exp_addr[k] = model_addr(32'h0, bus.i_in, bus.j_in, bus.n_in, k);
      end else if (m_issue) begin
         m_wait = 1;
      end else if (m_wait && bus.mem_rvalid) begin
         m_vec[32*m_lane +: 32] = bus.mem_rdata;
         m_wait = 0;
         if (m_lane == L - 1) nv = 1;
         else begin m_lane++; ni = 1; end
      end
      m_issue = ni;
      m_vv    = nv;
      m_cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      chk("busy", bus.busy, m_busy);
      chk("mem_rd_en", bus.mem_rd_en, m_issue);
      if (m_issue && bus.mem_rd_en) chk("mem_addr", bus.mem_addr, exp_addr[m_lane]);
      chk("vec_valid", bus.vec_valid, m_vv);
      chk("vec_out", bus.vec_out, m_vec);
      if (bus.mem_rd_en) begin addr_q.push_back(bus.mem_addr); rd_cnt++; end
      if (bus.vec_valid) begin vv_cnt++; last_lat = m_cyc; end
      if (bus.mem_rd_en) begin pend = 1; cnt = lat; paddr = bus.mem_addr; end
      nxt_rv = 0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin nxt_rv = 1; nxt_data = paddr + 32'd1; pend = 0; end
      end
      if (bus1.mem_rd_en) addr1_q.push_back(bus1.mem_addr);
      if (bus1.vec_valid) vv1_cnt++;
      nxt1      = bus1.mem_rd_en;
      nxt1_data = bus1.mem_addr + 32'd1;
      model_step();
      @(posedge clk);
      #1;
      bus.mem_rvalid  = nxt_rv;
      bus.mem_rdata   = nxt_rv ? nxt_data : 32'h0;
      bus1.mem_rvalid = nxt1;
      bus1.mem_rdata  = nxt1 ? nxt1_data : 32'h0;
   endtask

   task automatic issue(input logic [31:0] i, input logic [31:0] j, input logic [31:0] n);
      bus.i_in = i; bus.j_in = j; bus.n_in = n; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_until_idle(input int budget);
      for (int c = 0; c < budget && m_busy; c++) tick();
      chk("load_timeout", m_busy, 1'b0);
   endtask

   task automatic chk_seq(input string nm, input logic [31:0] q [$], input int s,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_count"}, q.size() - s, 4);
      for (int k = 0; k < 4; k++)
         chk(nm, (s + k < q.size()) ? q[s + k] : 32'hxxxx_xxxx, e[k]);
   endtask

   initial begin
      int s, v, r;
      rst = 1'b1;
      bus.start = 0; bus.i_in = 0; bus.j_in = 0; bus.n_in = 0;
      bus.mem_rvalid = 0; bus.mem_rdata = 0;
      bus1.start = 0; bus1.i_in = 0; bus1.j_in = 0; bus1.n_in = 0;
      bus1.mem_rvalid = 0; bus1.mem_rdata = 0;
      m_busy = 0; m_issue = 0; m_wait = 0; m_vv = 0; m_lane = 0; m_cyc = 0;
      m_vec = '0; vv_cnt = 0; rd_cnt = 0; last_lat = 0; vv1_cnt = 0; pend = 0; cnt = 0;
      @(posedge clk);
      #1;
      repeat (2) tick();
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rd_en", bus.mem_rd_en, 1'b0);
      chk("rst_vec_valid", bus.vec_valid, 1'b0);
      chk("rst_vec_out", bus.vec_out, '0);
      rst = 1'b0;
      tick();

      // basic load, 1-cycle memory
      s = addr_q.size(); v = vv_cnt;
      issue(1, 0, 3);
      run_until_idle(40);
      chk_seq("basic_addr", addr_q, s, 32'd16, 32'd20, 32'd24, 32'd28);
      chk("basic_vec", bus.vec_out, {32'd29, 32'd25, 32'd21, 32'd17});
      chk("basic_latency", last_lat, 9);
      chk("basic_vv_count", vv_cnt - v, 1);

      // column wrap, started in the first IDLE cycle after DONE
      s = addr_q.size(); v = vv_cnt;
      issue(1, 2, 3);
      run_until_idle(40);
      chk_seq("wrap_addr", addr_q, s, 32'd24, 32'd28, 32'd16, 32'd20);
      chk("wrap_vec", bus.vec_out, {32'd21, 32'd17, 32'd29, 32'd25});
      chk("wrap_vv_count", vv_cnt - v, 1);

      // 3-cycle memory, start during WAIT and DONE, stray rvalid during ISSUE
      lat = 3;
      s = addr_q.size(); v = vv_cnt; r = rd_cnt;
      issue(0, 1, 4);
      for (int c = 0; c < 50 && !(m_wait && m_lane == 1); c++) tick();
      chk("lat_reach_wait", m_wait && m_lane == 1, 1'b1);
      bus.i_in = 2; bus.j_in = 0; bus.n_in = 1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 50 && !(m_issue && m_lane == 2); c++) tick();
      chk("lat_reach_issue", m_issue && m_lane == 2, 1'b1);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
      tick();
      for (int c = 0; c < 50 && !m_vv; c++) tick();
      chk("lat_reach_done", m_vv, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      run_until_idle(40);
      repeat (3) tick();
      chk_seq("lat_addr", addr_q, s, 32'd4, 32'd8, 32'd12, 32'd16);
      chk("lat_vec", bus.vec_out, {32'd17, 32'd13, 32'd9, 32'd5});
      chk("lat_vv_count", vv_cnt - v, 1);
      chk("lat_rd_count", rd_cnt - r, 4);

      // reset during WAIT of lane 2, then stray rvalid in IDLE
      v = vv_cnt;
      issue(2, 3, 3);
      for (int c = 0; c < 50 && !(m_wait && m_lane == 2); c++) tick();
      chk("rst_reach_wait", m_wait && m_lane == 2, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("midrst_vec_zero", bus.vec_out, '0);
      chk("midrst_busy", bus.busy, 1'b0);
      repeat (6) tick();
      chk("midrst_no_vv", vv_cnt - v, 0);
      chk("midrst_vec_still_zero", bus.vec_out, '0);

      // fresh load after reset
      lat = 1;
      s = addr_q.size(); v = vv_cnt;
      issue(1, 0, 3);
      run_until_idle(40);
      chk_seq("fresh_addr", addr_q, s, 32'd16, 32'd20, 32'd24, 32'd28);
      chk("fresh_vec", bus.vec_out, {32'd29, 32'd25, 32'd21, 32'd17});
      chk("fresh_vv_count", vv_cnt - v, 1);

      // address overflow on the high-base instance
      s = addr1_q.size(); v = vv1_cnt;
      bus1.i_in = 0; bus1.j_in = 0; bus1.n_in = 7; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      for (int c = 0; c < 40 && vv1_cnt == v; c++) tick();
      chk("ovf_vv_count", vv1_cnt - v, 1);
      chk_seq("ovf_addr", addr1_q, s, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      chk("ovf_vec", bus1.vec_out, {32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF5, 32'hFFFF_FFF1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
